fetch_queue: RTL and testbench

Parametrised instruction fetch unit with a prefetch queue for the nibble-oriented CPU. It drives a synchronous program ROM, buffers fetched words in a small FIFO, and presents each word split into opcode and operand fields to decode over a valid/ready handshake. It supports branch redirection: a flush loads a new PC and squashes all queued and in-flight words. It sits between the program ROM and the decode/control stage.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_queue.sv | 85 ++++++++
 tb/tb_fetch_queue.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and queue-entry type for the fetch unit.
package fetch_pkg;

  localparam int IW_DEF    = 8;
  localparam int OPW_DEF   = 4;
  localparam int AW_DEF    = 12;
  localparam int DEPTH_DEF = 4;

  // Queue entry at the default widths; the top rebuilds the same layout from its parameters.
  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [IW_DEF-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO with synchronous clear; head is visible on dout while not empty.
module fetch_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is not reset; stale contents are never visible because dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit: drives a synchronous ROM and buffers words in a prefetch queue for decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int IW    = IW_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  input  logic [AW-1:0]              flush_pc,
  output logic                       rom_req,
  output logic [AW-1:0]              rom_addr,
  input  logic [IW-1:0]              rom_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OPW-1:0]             instr,
  output logic [IW-OPW-1:0]          oprnd,
  output logic [AW-1:0]              instr_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] word;
  } entry_t;

  logic          [AW-1:0] pc, pend_addr;
  logic                   pend;
  logic          [CW:0]   inflight;
  logic                   fifo_empty, fifo_full, pop;
  entry_t                 push_entry, head;

  // Credit: queued words plus the one in flight must leave room for a new request.
  assign inflight = (CW+1)'(count) + (CW+1)'(pend);
  assign rom_req  = !reset && enable && !flush && !fifo_full && (inflight < (CW+1)'(DEPTH));
  assign rom_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
    end else if (flush) begin
      pc   <= flush_pc;
      pend <= 1'b0;
    end else begin
      pend <= rom_req;
      if (rom_req) begin
        pc        <= pc + 1'b1;
        pend_addr <= pc;
      end
    end
  end

  assign push_entry = '{addr: pend_addr, word: rom_data};
  assign out_valid  = !fifo_empty && enable && !flush;
  assign pop        = out_valid && out_ready;

  fetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (pend && !flush),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instr    = head.word[IW-1 -: OPW];
  assign oprnd    = head.word[IW-OPW-1:0];
  assign instr_pc = head.addr;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a queue-based reference of the fetch/present rules.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [11:0] flush_pc = '0;
  logic        rom_req;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  instr;
  logic [3:0]  oprnd;
  logic [11:0] instr_pc;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .rom_req   (rom_req),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .oprnd     (oprnd),
    .instr_pc  (instr_pc),
    .count     (count)
  );

  logic [7:0] mem [4096];
  always @(posedge clk) rom_data <= mem[rom_addr];

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  word;
  } ent_t;

  ent_t        mq[$];
  logic [11:0] mpc, mpend_addr;
  logic        mpend, exp_req, exp_pop;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = '0;
    mpend = 1'b0;
    mpend_addr = '0;
  endtask

  task automatic compare();
    logic exp_valid;
    exp_valid = (mq.size() > 0) && enable && !flush;
    exp_req   = enable && !flush && (mq.size() + int'(mpend)) < 4;
    exp_pop   = exp_valid && out_ready;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("count", 32'(count), 32'(mq.size()));
    check("rom_req", 32'(rom_req), 32'(exp_req));
    check("rom_addr", 32'(rom_addr), 32'(mpc));
    if (mq.size() > 0) begin
      check("instr", 32'(instr), 32'(mq[0].word >> 4));
      check("oprnd", 32'(oprnd), 32'(mq[0].word & 8'h0F));
      check("instr_pc", 32'(instr_pc), 32'(mq[0].addr));
    end else begin
      check("empty_fields", {20'd0, instr_pc}, 32'd0);
      check("empty_instr", {24'd0, instr, oprnd}, 32'd0);
    end
  endtask

  // One clock: drive at the falling edge, compare once settled, advance the model at the rising edge.
  task automatic step(input logic en, input logic fl, input logic [11:0] fpc, input logic rdy);
    @(negedge clk);
    reset = 1'b0;
    enable = en;
    flush = fl;
    flush_pc = fpc;
    out_ready = rdy;
    #1 compare();
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mpend = 1'b0;
      mpc = fpc;
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (mpend) mq.push_back('{addr: mpend_addr, word: mem[mpend_addr]});
      mpend = exp_req;
      if (exp_req) begin
        mpend_addr = mpc;
        mpc = mpc + 12'd1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i + 'h10);
    model_reset();
    repeat (2) @(posedge clk);

    // Stream from reset: first word (mem[0]=0x10) presented two cycles after release.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Backpressure: queue saturates and requests stop.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    #1 check("bp_count_sat", 32'(count), 32'd4);
    check("bp_req_off", 32'(rom_req), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Flush squash while three words are queued and one is in flight.
    begin
      int budget = 20;
      while (!(mq.size() == 3 && mpend) && budget > 0) begin
        step(1'b1, 1'b0, '0, 1'b0);
        budget--;
      end
      check("flush_setup_reached", 32'(budget > 0), 32'd1);
    end
    step(1'b1, 1'b1, 12'h0A0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);

    // PC wrap across the top of the address space.
    step(1'b1, 1'b1, 12'hFFE, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Enable gating mid-stream.
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rom_req", 32'(rom_req), 32'd0);
    check("rst_fields", {instr_pc, instr, oprnd}, 32'd0);
    model_reset();
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    @(posedge clk);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);

    // Random mix of stalls, enable gaps and redirects.
    for (int i = 0; i < 600; i++) begin
      logic        en, fl, rdy;
      logic [11:0] fpc;
      en  = ($urandom_range(0, 9) != 0);
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      fpc = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3)) : 12'($urandom);
      step(en, fl, fpc, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
